modulator_symbol_mapper: RTL

- Transmit-side counterpart of the demodulator chain: converts a byte stream into a constellation-mapped, zero-stuffed complex baseband sample stream.
- Runtime-selectable BPSK / QPSK / 8PSK / 16QAM.
- Output samples are signed I/Q pairs, consumed downstream by the pulse-shaping filter.
- AXI-stream-style valid/ready on both sides.

---
 rtl/modulator_symbol_mapper.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/modulator_symbol_mapper.sv
// Byte stream to BPSK/QPSK/8PSK/16QAM I/Q samples, each symbol followed by SPS-1 zero samples.
// Define MODULATOR_SYMBOL_MAPPER_SCRAMBLER_EN to XOR input bits with a x^15+x^14+1 PRBS.
module modulator_symbol_mapper #(
  parameter int W   = 8,
  parameter int SPS = 4
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic [1:0]          imode,
  input  logic [7:0]          i_tdata,
  input  logic                i_tvalid,
  output logic                o_tready,
  output logic                o_tvalid,
  output logic signed [W-1:0] o_i,
  output logic signed [W-1:0] o_q,
  input  logic                i_tready
);
  localparam int     CW    = (SPS > 1) ? $clog2(SPS) : 1;
  localparam longint AMP_L = (longint'(1) << (W-1)) - 1;

  // round-to-nearest of a*num/den in integer arithmetic, evaluated at elaboration
  function automatic longint round_frac(input longint a, input longint num, input longint den);
    return (2 * a * num + den) / (2 * den);
  endfunction

  localparam logic signed [W-1:0] AMP = W'(AMP_L);
  localparam logic signed [W-1:0] C   = W'(round_frac(AMP_L, 70711, 100000));
  localparam logic signed [W-1:0] C1  = W'(round_frac(AMP_L, 92388, 100000));
  localparam logic signed [W-1:0] C2  = W'(round_frac(AMP_L, 38268, 100000));
  localparam logic signed [W-1:0] A3  = W'(round_frac(AMP_L, 1, 3));

  function automatic logic signed [W-1:0] qam_level(input logic [1:0] b);
    case (b)
      2'b00:   return AMP;
      2'b01:   return A3;
      2'b11:   return -A3;
      default: return -AMP;
    endcase
  endfunction

  // b holds the oldest buffered bits MSB-aligned; only the top bps bits matter
  function automatic logic [2*W-1:0] map_symbol(input logic [1:0] m, input logic [3:0] b);
    logic signed [W-1:0] si;
    logic signed [W-1:0] sq;
    si = '0;
    sq = '0;
    case (m)
      2'd0: si = b[3] ? -AMP : AMP;
      2'd1: begin
        si = b[3] ? -C : C;
        sq = b[2] ? -C : C;
      end
      2'd2: begin
        case (b[3:1])
          3'b000:  begin si = C1;  sq = C2;  end
          3'b001:  begin si = C2;  sq = C1;  end
          3'b011:  begin si = -C2; sq = C1;  end
          3'b010:  begin si = -C1; sq = C2;  end
          3'b110:  begin si = -C1; sq = -C2; end
          3'b111:  begin si = -C2; sq = -C1; end
          3'b101:  begin si = C2;  sq = -C1; end
          default: begin si = C1;  sq = -C2; end
        endcase
      end
      default: begin
        si = qam_level(b[3:2]);
        sq = qam_level(b[1:0]);
      end
    endcase
    return {si, sq};
  endfunction

  logic [15:0]         sr_p0;
  logic [4:0]          cnt_p0;
  logic [CW-1:0]       sps_cnt;
  logic [1:0]          mode_r;
  logic signed [W-1:0] i_p1;
  logic signed [W-1:0] q_p1;
  logic                vld_p1;

  logic [2:0]  bps;
  logic        free;
  logic        accept;
  logic        pop;
  logic        stuff;
  logic [4:0]  rem;
  logic [15:0] sr_shift;
  logic [15:0] sr_next;
  logic [4:0]  cnt_next;
  logic [7:0]  byte_in;

  assign o_tready = (cnt_p0 <= 5'd8);

`ifdef MODULATOR_SYMBOL_MAPPER_SCRAMBLER_EN
  logic [14:0] lfsr;
  logic [14:0] lfsr_next;
  logic [7:0]  prbs;

  // PRBS output is the LFSR MSB; the first output scrambles the byte MSB
  always_comb begin
    lfsr_next = lfsr;
    prbs      = '0;
    for (int k = 7; k >= 0; k--) begin
      prbs[k]   = lfsr_next[14];
      lfsr_next = {lfsr_next[13:0], lfsr_next[14] ^ lfsr_next[13]};
    end
  end

  assign byte_in = i_tdata ^ prbs;

  always_ff @(posedge iclk) begin
    if (ireset)      lfsr <= 15'h7FFF;
    else if (accept) lfsr <= lfsr_next;
  end
`else
  assign byte_in = i_tdata;
`endif

  always_comb begin
    bps      = {1'b0, mode_r} + 3'd1;
    free     = !vld_p1 || i_tready;
    accept   = i_tvalid && o_tready;
    pop      = free && (sps_cnt == '0) && (cnt_p0 >= {2'b00, bps});
    stuff    = free && (sps_cnt != '0);
    rem      = pop ? (cnt_p0 - {2'b00, bps}) : cnt_p0;
    sr_shift = pop ? (sr_p0 << bps) : sr_p0;
    // new byte lands directly behind the bits that survive this cycle's pop
    sr_next  = accept ? (sr_shift | ({byte_in, 8'h00} >> rem)) : sr_shift;
    cnt_next = rem + (accept ? 5'd8 : 5'd0);
  end

  // Stage p0: bit buffer, mode latch, zero-stuff counter
  // Stage p1: registered constellation point or stuffed zero
  always_ff @(posedge iclk) begin
    if (ireset) begin
      sr_p0   <= '0;
      cnt_p0  <= '0;
      sps_cnt <= '0;
      mode_r  <= '0;
      vld_p1  <= 1'b0;
      i_p1    <= '0;
      q_p1    <= '0;
    end else begin
      sr_p0  <= sr_next;
      cnt_p0 <= cnt_next;
      if ((cnt_p0 == '0) && (sps_cnt == '0)) mode_r <= imode;
      if (pop) begin
        {i_p1, q_p1} <= map_symbol(mode_r, sr_p0[15:12]);
        vld_p1       <= 1'b1;
        sps_cnt      <= CW'(SPS - 1);
      end else if (stuff) begin
        i_p1    <= '0;
        q_p1    <= '0;
        vld_p1  <= 1'b1;
        sps_cnt <= sps_cnt - 1'b1;
      end else if (free) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign o_tvalid = vld_p1;
  assign o_i      = i_p1;
  assign o_q      = q_p1;

endmodule
